// File: rtl/dm_bus_arbiter_if.sv
// Bundle of signals between the bus arbiter, its two masters and the shared slave.
//   m0_* / m1_* : request (req, addr, we, be, wdata) and response (gnt, rvalid, rdata, err)
//   s_*         : shared slave access (req, addr, we, be, wdata out; rdata, ready in)
//   busy        : arbiter is not idle
// Modport slave is the arbiter's view. Modport master is the view of the environment
// (masters plus slave).
interface dm_bus_arbiter_if;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = 4;

   logic          m0_req;
   logic [AW-1:0] m0_addr;
   logic          m0_we;
   logic [BW-1:0] m0_be;
   logic [DW-1:0] m0_wdata;
   logic          m0_gnt;
   logic          m0_rvalid;
   logic [DW-1:0] m0_rdata;
   logic          m0_err;

   logic          m1_req;
   logic [AW-1:0] m1_addr;
   logic          m1_we;
   logic [BW-1:0] m1_be;
   logic [DW-1:0] m1_wdata;
   logic          m1_gnt;
   logic          m1_rvalid;
   logic [DW-1:0] m1_rdata;
   logic          m1_err;

   logic          s_req;
   logic [AW-1:0] s_addr;
   logic          s_we;
   logic [BW-1:0] s_be;
   logic [DW-1:0] s_wdata;
   logic [DW-1:0] s_rdata;
   logic          s_ready;

   logic          busy;

   modport slave (
      input  m0_req, m0_addr, m0_we, m0_be, m0_wdata,
      output m0_gnt, m0_rvalid, m0_rdata, m0_err,
      input  m1_req, m1_addr, m1_we, m1_be, m1_wdata,
      output m1_gnt, m1_rvalid, m1_rdata, m1_err,
      output s_req, s_addr, s_we, s_be, s_wdata,
      input  s_rdata, s_ready,
      output busy
   );

   modport master (
      output m0_req, m0_addr, m0_we, m0_be, m0_wdata,
      input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
      output m1_req, m1_addr, m1_we, m1_be, m1_wdata,
      input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
      input  s_req, s_addr, s_we, s_be, s_wdata,
      output s_rdata, s_ready,
      input  busy
   );
endinterface

// File: rtl/dm_bus_arbiter.sv
// Two-master, single-slave arbiter for the data-memory / peripheral bus.
// Grants one transaction at a time and drives the slave from registered copies of
// the request. It then returns the read data, or a timeout error, to the owner.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : dm_bus_arbiter_if.slave (master requests/responses, slave bus, busy)
// mX_gnt is combinational in IDLE. All other outputs are registered.
module dm_bus_arbiter #(
   parameter int unsigned TIMEOUT    = 16,
   parameter bit          FIXED_PRIO = 1'b0
) (
   input logic             clk,
   input logic             reset,
   dm_bus_arbiter_if.slave bus
);
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = 4;
   localparam int unsigned CW = 8;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t                 state_q, state_d;
   logic                   owner_q, owner_d;
   logic                   last_grant_q, last_grant_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   s_req_q, s_req_d;
   logic [AW-1:0]          s_addr_q, s_addr_d;
   logic                   s_we_q, s_we_d;
   logic [BW-1:0]          s_be_q, s_be_d;
   logic [DW-1:0]          s_wdata_q, s_wdata_d;
   logic [1:0]             rvalid_q, rvalid_d;
   logic [1:0][DW-1:0]     rdata_q, rdata_d;
   logic [1:0]             err_q, err_d;
   logic                   busy_q, busy_d;
   logic [1:0]             gnt_c;
   logic                   req_any;
   logic                   winner;

   // Arbitration: a tie goes to m0 under fixed priority, otherwise to the master not served last.
   always_comb begin
      req_any = bus.m0_req | bus.m1_req;
      if (bus.m0_req && bus.m1_req) begin
         winner = FIXED_PRIO ? 1'b0 : ~last_grant_q;
      end else begin
         winner = bus.m1_req;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         s_req_q      <= 1'b0;
         s_addr_q     <= '0;
         s_we_q       <= 1'b0;
         s_be_q       <= '0;
         s_wdata_q    <= '0;
         rvalid_q     <= '0;
         rdata_q      <= '0;
         err_q        <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         s_req_q      <= s_req_d;
         s_addr_q     <= s_addr_d;
         s_we_q       <= s_we_d;
         s_be_q       <= s_be_d;
         s_wdata_q    <= s_wdata_d;
         rvalid_q     <= rvalid_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
         busy_q       <= busy_d;
      end
   end

   // Next state, grant and registered-output next values.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      s_req_d      = 1'b0;
      s_addr_d     = s_addr_q;
      s_we_d       = s_we_q;
      s_be_d       = s_be_q;
      s_wdata_d    = s_wdata_q;
      rvalid_d     = '0;
      rdata_d      = rdata_q;
      err_d        = err_q;
      gnt_c        = '0;

      case (state_q)
         IDLE: begin
            if (req_any) begin
               gnt_c[winner] = 1'b1;
               s_addr_d      = winner ? bus.m1_addr  : bus.m0_addr;
               s_we_d        = winner ? bus.m1_we    : bus.m0_we;
               s_be_d        = winner ? bus.m1_be    : bus.m0_be;
               s_wdata_d     = winner ? bus.m1_wdata : bus.m0_wdata;
               owner_d       = winner;
               last_grant_d  = winner;
               cnt_d         = '0;
               s_req_d       = 1'b1;
               state_d       = BUSY;
            end
         end
         BUSY: begin
            s_req_d = 1'b1;
            // A ready in the threshold cycle wins over the timeout.
            if (bus.s_ready) begin
               rdata_d[owner_q]  = s_we_q ? '0 : bus.s_rdata;
               err_d[owner_q]    = 1'b0;
               rvalid_d[owner_q] = 1'b1;
               s_req_d           = 1'b0;
               state_d           = RESP;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               rdata_d[owner_q]  = '0;
               err_d[owner_q]    = 1'b1;
               rvalid_d[owner_q] = 1'b1;
               s_req_d           = 1'b0;
               state_d           = RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   assign bus.m0_gnt    = gnt_c[0];
   assign bus.m1_gnt    = gnt_c[1];
   assign bus.m0_rvalid = rvalid_q[0];
   assign bus.m1_rvalid = rvalid_q[1];
   assign bus.m0_rdata  = rdata_q[0];
   assign bus.m1_rdata  = rdata_q[1];
   assign bus.m0_err    = err_q[0];
   assign bus.m1_err    = err_q[1];
   assign bus.s_req     = s_req_q;
   assign bus.s_addr    = s_addr_q;
   assign bus.s_we      = s_we_q;
   assign bus.s_be      = s_be_q;
   assign bus.s_wdata   = s_wdata_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Scoreboard bench for dm_bus_arbiter.
// Two instances share the stimulus: u_rr is round-robin and u_fp is fixed priority.
// sel routes the requests to one instance and picks the outputs to observe.
module tb_dm_bus_arbiter;
   typedef struct packed {
      logic        m;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } req_t;

   typedef struct packed {
      logic        m;
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sel = 1'b0;

   logic        m0_req = 1'b0, m1_req = 1'b0;
   logic [31:0] m0_addr = '0, m1_addr = '0;
   logic        m0_we = 1'b0, m1_we = 1'b0;
   logic [3:0]  m0_be = '0, m1_be = '0;
   logic [31:0] m0_wdata = '0, m1_wdata = '0;
   logic [31:0] s_rdata = '0;
   logic        s_ready = 1'b0;

   logic        gnt0, gnt1, rv0, rv1, err0, err1, mon_s_req, mon_s_we, mon_busy;
   logic [31:0] rd0, rd1, mon_s_addr, mon_s_wdata;
   logic [3:0]  mon_s_be;

   int   n_tests = 0;
   int   n_fail = 0;
   int   cyc = 0;
   req_t exp_gnt[$];
   rsp_t exp_rsp[$];
   int   gnt_cyc_q[$];
   req_t cur_req = '0;
   int   sreq_len = 0, last_sreq_len = 0, sreq_rise_cyc = 0;
   int   rsp_cyc = 0, ready_cyc = 0;
   int   slv_cnt = 0, ready_at = 0;
   logic [31:0] key = '0;

   dm_bus_arbiter_if bus_a ();
   dm_bus_arbiter_if bus_b ();

   dm_bus_arbiter #(.TIMEOUT(16), .FIXED_PRIO(1'b0)) u_rr (.clk(clk), .reset(reset), .bus(bus_a));
   dm_bus_arbiter #(.TIMEOUT(16), .FIXED_PRIO(1'b1)) u_fp (.clk(clk), .reset(reset), .bus(bus_b));

   assign bus_a.m0_req = m0_req & ~sel;
   assign bus_a.m1_req = m1_req & ~sel;
   assign bus_b.m0_req = m0_req & sel;
   assign bus_b.m1_req = m1_req & sel;
   assign bus_a.m0_addr = m0_addr;   assign bus_b.m0_addr = m0_addr;
   assign bus_a.m0_we = m0_we;       assign bus_b.m0_we = m0_we;
   assign bus_a.m0_be = m0_be;       assign bus_b.m0_be = m0_be;
   assign bus_a.m0_wdata = m0_wdata; assign bus_b.m0_wdata = m0_wdata;
   assign bus_a.m1_addr = m1_addr;   assign bus_b.m1_addr = m1_addr;
   assign bus_a.m1_we = m1_we;       assign bus_b.m1_we = m1_we;
   assign bus_a.m1_be = m1_be;       assign bus_b.m1_be = m1_be;
   assign bus_a.m1_wdata = m1_wdata; assign bus_b.m1_wdata = m1_wdata;
   assign bus_a.s_rdata = s_rdata;   assign bus_b.s_rdata = s_rdata;
   assign bus_a.s_ready = s_ready & ~sel;
   assign bus_b.s_ready = s_ready & sel;

   assign gnt0        = sel ? bus_b.m0_gnt    : bus_a.m0_gnt;
   assign gnt1        = sel ? bus_b.m1_gnt    : bus_a.m1_gnt;
   assign rv0         = sel ? bus_b.m0_rvalid : bus_a.m0_rvalid;
   assign rv1         = sel ? bus_b.m1_rvalid : bus_a.m1_rvalid;
   assign rd0         = sel ? bus_b.m0_rdata  : bus_a.m0_rdata;
   assign rd1         = sel ? bus_b.m1_rdata  : bus_a.m1_rdata;
   assign err0        = sel ? bus_b.m0_err    : bus_a.m0_err;
   assign err1        = sel ? bus_b.m1_err    : bus_a.m1_err;
   assign mon_s_req   = sel ? bus_b.s_req     : bus_a.s_req;
   assign mon_s_addr  = sel ? bus_b.s_addr    : bus_a.s_addr;
   assign mon_s_we    = sel ? bus_b.s_we      : bus_a.s_we;
   assign mon_s_be    = sel ? bus_b.s_be      : bus_a.s_be;
   assign mon_s_wdata = sel ? bus_b.s_wdata   : bus_a.s_wdata;
   assign mon_busy    = sel ? bus_b.busy      : bus_a.busy;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   function automatic req_t mk_req(input logic m, input logic [31:0] a, input logic we,
                                   input logic [3:0] be, input logic [31:0] wd);
      mk_req = {m, a, we, be, wd};
   endfunction

   function automatic rsp_t mk_rsp(input logic m, input logic [31:0] rd, input logic e);
      mk_rsp = {m, rd, e};
   endfunction

   // Slave model: ready in the ready_at-th cycle of s_req (0 = never), data derived from the address.
   always @(negedge clk) begin
      if (mon_s_req) begin
         slv_cnt++;
         s_ready = (ready_at != 0) && (slv_cnt == ready_at);
         if (s_ready) ready_cyc = cyc;
      end else begin
         slv_cnt = 0;
         s_ready = 1'b0;
      end
      s_rdata = mon_s_addr ^ key;
   end

   // Grant monitor.
   always @(negedge clk) begin
      if (gnt0 || gnt1) begin
         gnt_cyc_q.push_back(cyc);
         check("gnt_in_idle", {31'd0, mon_busy}, 32'd0);
         check("gnt_onehot", {30'd0, gnt1, gnt0}, gnt1 ? 32'd2 : 32'd1);
         if (exp_gnt.size() == 0) begin
            check("gnt_unexpected", {30'd0, gnt1, gnt0}, 32'd0);
         end else begin
            cur_req = exp_gnt.pop_front();
            check("gnt_who", {31'd0, gnt1}, {31'd0, cur_req.m});
         end
      end
   end

   // Slave-bus monitor: the registered request must match the granted one in every BUSY cycle.
   always @(negedge clk) begin
      if (mon_s_req) begin
         sreq_len++;
         if (sreq_len == 1) sreq_rise_cyc = cyc;
         check("s_addr", mon_s_addr, cur_req.addr);
         check("s_we", {31'd0, mon_s_we}, {31'd0, cur_req.we});
         check("s_be", {28'd0, mon_s_be}, {28'd0, cur_req.be});
         check("s_wdata", mon_s_wdata, cur_req.wdata);
         check("s_req_busy", {31'd0, mon_busy}, 32'd1);
      end else if (sreq_len != 0) begin
         last_sreq_len = sreq_len;
         sreq_len = 0;
      end
   end

   // Response monitor.
   always @(negedge clk) begin
      rsp_t e;
      if (rv0 || rv1) begin
         rsp_cyc = cyc;
         check("rsp_onehot", {30'd0, rv1, rv0}, rv1 ? 32'd2 : 32'd1);
         check("rsp_sreq_low", {31'd0, mon_s_req}, 32'd0);
         if (exp_rsp.size() == 0) begin
            check("rsp_unexpected", {30'd0, rv1, rv0}, 32'd0);
         end else begin
            e = exp_rsp.pop_front();
            check("rsp_who", {31'd0, rv1}, {31'd0, e.m});
            check("rsp_rdata", rv1 ? rd1 : rd0, e.rdata);
            check("rsp_err", {31'd0, rv1 ? err1 : err0}, {31'd0, e.err});
         end
      end
   end

   // Reset with sel routing to the chosen instance, then check the reset values.
   task automatic apply_reset(input logic which);
      @(posedge clk); #1;
      sel = which;
      reset = 1'b1;
      m0_req = 1'b0;
      m1_req = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", {31'd0, mon_busy}, 32'd0);
      check("rst_sreq", {31'd0, mon_s_req}, 32'd0);
      check("rst_saddr", mon_s_addr, 32'd0);
      check("rst_rvalid", {30'd0, rv1, rv0}, 32'd0);
      check("rst_rdata", rd0 | rd1, 32'd0);
      check("rst_err", {30'd0, err1, err0}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      gnt_cyc_q.delete();
   endtask

   // Wait for n grants (bounded), then return just after the edge that took the last one.
   task automatic wait_gnts(input string name, input int n, input int budget);
      int cnt = 0;
      int t = 0;
      while (cnt < n && t < budget) begin
         @(negedge clk);
         t++;
         if (gnt0 || gnt1) cnt++;
      end
      if (cnt < n) check(name, cnt, n);
      @(posedge clk); #1;
   endtask

   // Wait until every expected grant and response has been seen and the arbiter is idle.
   task automatic wait_done(input string name, input int budget);
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while ((exp_gnt.size() != 0 || exp_rsp.size() != 0 || mon_busy) && t < budget);
      if (exp_gnt.size() != 0 || exp_rsp.size() != 0 || mon_busy)
         check(name, exp_gnt.size() + exp_rsp.size(), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Single read.
      apply_reset(1'b0);
      key = 32'hDEADBEEF ^ 32'h0000_1004;
      ready_at = 1;
      exp_gnt.push_back(mk_req(1'b0, 32'h0000_1004, 1'b0, 4'hF, 32'h0));
      exp_rsp.push_back(mk_rsp(1'b0, 32'hDEADBEEF, 1'b0));
      m0_addr = 32'h0000_1004; m0_we = 1'b0; m0_be = 4'hF; m0_wdata = 32'h0; m0_req = 1'b1;
      wait_gnts("t1_gnt", 1, 20);
      m0_req = 1'b0;
      wait_done("t1_done", 40);
      if (gnt_cyc_q.size() >= 1) begin
         check("t1_lat_sreq", sreq_rise_cyc - gnt_cyc_q[0], 32'd1);
         check("t1_lat_rvalid", rsp_cyc - gnt_cyc_q[0], 32'd2);
      end

      // Round-robin with both masters requesting continuously.
      apply_reset(1'b0);
      key = 32'hA5A5_0000;
      ready_at = 1;
      m0_addr = 32'h100; m0_we = 1'b0; m0_be = 4'hF; m0_wdata = 32'h0;
      m1_addr = 32'h200; m1_we = 1'b0; m1_be = 4'hF; m1_wdata = 32'h0;
      for (int i = 0; i < 4; i++) begin
         exp_gnt.push_back(mk_req(i[0], i[0] ? 32'h200 : 32'h100, 1'b0, 4'hF, 32'h0));
         exp_rsp.push_back(mk_rsp(i[0], i[0] ? 32'hA5A5_0200 : 32'hA5A5_0100, 1'b0));
      end
      m0_req = 1'b1; m1_req = 1'b1;
      wait_gnts("t2_gnt", 4, 40);
      m0_req = 1'b0; m1_req = 1'b0;
      wait_done("t2_done", 40);
      if (gnt_cyc_q.size() == 4)
         for (int i = 1; i < 4; i++) check("t2_spacing", gnt_cyc_q[i] - gnt_cyc_q[i-1], 32'd3);
      else
         check("t2_ngnt", gnt_cyc_q.size(), 32'd4);

      // Fixed priority: m1 waits until m0 drops its request.
      apply_reset(1'b1);
      for (int i = 0; i < 3; i++) begin
         exp_gnt.push_back(mk_req(1'b0, 32'h100, 1'b0, 4'hF, 32'h0));
         exp_rsp.push_back(mk_rsp(1'b0, 32'hA5A5_0100, 1'b0));
      end
      exp_gnt.push_back(mk_req(1'b1, 32'h200, 1'b0, 4'hF, 32'h0));
      exp_rsp.push_back(mk_rsp(1'b1, 32'hA5A5_0200, 1'b0));
      m0_req = 1'b1; m1_req = 1'b1;
      wait_gnts("t3_gnt_m0", 3, 40);
      m0_req = 1'b0;
      wait_gnts("t3_gnt_m1", 1, 20);
      m1_req = 1'b0;
      wait_done("t3_done", 40);
      if (gnt_cyc_q.size() == 4) check("t3_m1_first_idle", gnt_cyc_q[3] - gnt_cyc_q[2], 32'd3);
      else check("t3_ngnt", gnt_cyc_q.size(), 32'd4);

      // Wait states on an m1 write; inputs change after the grant.
      apply_reset(1'b0);
      ready_at = 6;
      exp_gnt.push_back(mk_req(1'b1, 32'h300, 1'b1, 4'b0011, 32'h1234_5678));
      exp_rsp.push_back(mk_rsp(1'b1, 32'h0, 1'b0));
      m1_addr = 32'h300; m1_we = 1'b1; m1_be = 4'b0011; m1_wdata = 32'h1234_5678; m1_req = 1'b1;
      wait_gnts("t4_gnt", 1, 20);
      m1_req = 1'b0; m1_addr = 32'hFFFF_FFFC; m1_we = 1'b0; m1_be = 4'hF; m1_wdata = 32'hFFFF_FFFF;
      wait_done("t4_done", 40);
      check("t4_rvalid_after_ready", rsp_cyc - ready_cyc, 32'd1);
      check("t4_busy_len", last_sreq_len, 32'd6);

      // Timeout, then ready arriving in the threshold cycle.
      apply_reset(1'b0);
      ready_at = 0;
      exp_gnt.push_back(mk_req(1'b0, 32'h400, 1'b0, 4'hF, 32'h0));
      exp_rsp.push_back(mk_rsp(1'b0, 32'h0, 1'b1));
      m0_addr = 32'h400; m0_req = 1'b1;
      wait_gnts("t5_gnt", 1, 20);
      m0_req = 1'b0;
      wait_done("t5_done", 40);
      check("t5_busy_len", last_sreq_len, 32'd16);
      check("t5_rsp_lat", rsp_cyc - sreq_rise_cyc, 32'd16);
      ready_at = 16;
      exp_gnt.push_back(mk_req(1'b0, 32'h404, 1'b0, 4'hF, 32'h0));
      exp_rsp.push_back(mk_rsp(1'b0, 32'hA5A5_0404, 1'b0));
      m0_addr = 32'h404; m0_req = 1'b1;
      wait_gnts("t5b_gnt", 1, 20);
      m0_req = 1'b0;
      wait_done("t5b_done", 40);
      check("t5b_busy_len", last_sreq_len, 32'd16);

      // Reset in the third BUSY cycle, then a tie goes to m0.
      apply_reset(1'b0);
      ready_at = 0;
      exp_gnt.push_back(mk_req(1'b0, 32'h500, 1'b0, 4'hF, 32'h0));
      m0_addr = 32'h500; m0_req = 1'b1;
      wait_gnts("t6_gnt", 1, 20);
      m0_req = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("t6_sreq", {31'd0, mon_s_req}, 32'd0);
      check("t6_busy", {31'd0, mon_busy}, 32'd0);
      check("t6_rvalid", {30'd0, rv1, rv0}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("t6_busy_len", last_sreq_len, 32'd3);
      repeat (20) @(negedge clk);
      @(posedge clk); #1;
      exp_gnt.push_back(mk_req(1'b0, 32'h600, 1'b0, 4'hF, 32'h0));
      exp_rsp.push_back(mk_rsp(1'b0, 32'hA5A5_0600, 1'b0));
      exp_gnt.push_back(mk_req(1'b1, 32'h700, 1'b0, 4'hF, 32'h0));
      exp_rsp.push_back(mk_rsp(1'b1, 32'hA5A5_0700, 1'b0));
      ready_at = 1;
      m0_addr = 32'h600; m1_addr = 32'h700; m1_we = 1'b0; m1_be = 4'hF; m1_wdata = 32'h0;
      m0_req = 1'b1; m1_req = 1'b1;
      wait_gnts("t6_tie_gnt", 1, 20);
      m0_req = 1'b0;
      wait_gnts("t6_m1_gnt", 1, 20);
      m1_req = 1'b0;
      wait_done("t6_done", 40);

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
